// File: rtl/sram_req_arbiter.sv
// Arbitrates the CPU fetch and load/store like-SRAM ports onto one shared master port.
// Responses are routed in order through an owner FIFO. Define ARB_ROUND_ROBIN_EN for alternating priority.
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_FIFO_AW      = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        busy,
    output logic        err_stray_ok
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    localparam int         DEPTH   = 1 << ID_FIFO_AW;
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    state_t                state_q, state_d;
    logic [2:0]            count_q;
    logic [ID_FIFO_AW-1:0] wptr_q, rptr_q;
    logic [DEPTH-1:0]      owner_q;
    logic                  stray_q;

    logic full, empty;
    logic win_data, win_valid;
    logic sel_data;
    logic accept, pop, head;

    assign full  = (count_q == MAX_CNT);
    assign empty = (count_q == 3'd0);

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data side wins a contended cycle; flips away from each contended winner
    logic prio_data_q;
    assign win_data = data_req & (prio_data_q | ~inst_req);
`else
    assign win_data = data_req;
`endif
    assign win_valid = (inst_req | data_req) & ~full;

    always_comb begin
        state_d  = state_q;
        sel_data = 1'b0;
        m_req    = 1'b0;
        case (state_q)
            IDLE: begin
                sel_data = win_data;
                m_req    = win_valid;
                if (win_valid && !m_addr_ok)
                    state_d = win_data ? LOCK_D : LOCK_I;
            end
            LOCK_I: begin
                sel_data = 1'b0;
                m_req    = inst_req;
                if (inst_req && m_addr_ok)
                    state_d = IDLE;
            end
            LOCK_D: begin
                sel_data = 1'b1;
                m_req    = data_req;
                if (data_req && m_addr_ok)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_wr    = sel_data ? data_wr    : inst_wr;
    assign m_size  = sel_data ? data_size  : inst_size;
    assign m_wstrb = sel_data ? data_wstrb : inst_wstrb;
    assign m_addr  = sel_data ? data_addr  : inst_addr;
    assign m_wdata = sel_data ? data_wdata : inst_wdata;

    assign accept       = m_req & m_addr_ok;
    assign inst_addr_ok = accept & ~sel_data;
    assign data_addr_ok = accept & sel_data;

    // Responses come back in acceptance order, so the FIFO head names the requester
    assign pop          = m_data_ok & ~empty;
    assign head         = owner_q[rptr_q];
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    assign busy         = ~empty | (state_q != IDLE);
    assign err_stray_ok = stray_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept)
                wptr_q <= wptr_q + ID_FIFO_AW'(1);
            if (pop)
                rptr_q <= rptr_q + ID_FIFO_AW'(1);
            case ({accept, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            if (m_data_ok && empty)
                stray_q <= 1'b1;
        end
    end

    // FIFO storage needs no reset: entries are only read while count_q covers them
    always_ff @(posedge clk) begin
        if (accept)
            owner_q[wptr_q] <= sel_data;
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst)
            prio_data_q <= 1'b1;
        else if (state_q == IDLE && win_valid && inst_req && data_req)
            prio_data_q <= ~win_data;
    end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: queue-based reference model checked every cycle plus literal spot checks.
module tb_sram_req_arbiter;

    localparam int MAX = 2;

    logic        clk, rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        busy, err_stray_ok;

    int n_cmp = 0;
    int n_bad = 0;

    sram_req_arbiter #(.MAX_OUTSTANDING(MAX), .ID_FIFO_AW(1)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy), .err_stray_ok(err_stray_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owners of outstanding transactions in a queue, plus who holds the port
    bit q[$];
    int lock    = 0;    // 0 none, 1 inst, 2 data
    bit stray_m = 1'b0;
    bit prio_m  = 1'b1; // data first

    always @(negedge clk) begin
        int   sel;
        logic exp_req, eacc;
        bit   was_idle;
        if (rst) begin
            q.delete();
            lock    = 0;
            stray_m = 1'b0;
            prio_m  = 1'b1;
        end else begin
            was_idle = (lock == 0);
            if (lock == 1) begin
                sel = 1; exp_req = inst_req;
            end else if (lock == 2) begin
                sel = 2; exp_req = data_req;
            end else if (q.size() < MAX && (inst_req || data_req)) begin
                exp_req = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                if (inst_req && data_req) sel = prio_m ? 2 : 1;
                else                      sel = data_req ? 2 : 1;
`else
                sel = data_req ? 2 : 1;
`endif
            end else begin
                sel = 0; exp_req = 1'b0;
            end
            chk("m_req", m_req, exp_req);
            if (sel == 1) begin
                chk("m_wr", m_wr, inst_wr);       chk("m_size", m_size, inst_size);
                chk("m_wstrb", m_wstrb, inst_wstrb); chk("m_addr", m_addr, inst_addr);
                chk("m_wdata", m_wdata, inst_wdata);
            end else if (sel == 2) begin
                chk("m_wr", m_wr, data_wr);       chk("m_size", m_size, data_size);
                chk("m_wstrb", m_wstrb, data_wstrb); chk("m_addr", m_addr, data_addr);
                chk("m_wdata", m_wdata, data_wdata);
            end
            eacc = exp_req & m_addr_ok;
            chk("inst_addr_ok", inst_addr_ok, eacc && sel == 1);
            chk("data_addr_ok", data_addr_ok, eacc && sel == 2);
            chk("inst_data_ok", inst_data_ok, m_data_ok && q.size() > 0 && q[0] == 1'b0);
            chk("data_data_ok", data_data_ok, m_data_ok && q.size() > 0 && q[0] == 1'b1);
            chk("inst_rdata", inst_rdata, m_rdata);
            chk("data_rdata", data_rdata, m_rdata);
            chk("busy", busy, q.size() > 0 || lock != 0);
            chk("err_stray_ok", err_stray_ok, stray_m);
            if (m_data_ok) begin
                if (q.size() > 0) void'(q.pop_front());
                else stray_m = 1'b1;
            end
            if (eacc) begin
                q.push_back(sel == 2);
                lock = 0;
            end else if (was_idle && sel != 0) begin
                lock = sel;
            end
            if (was_idle && sel != 0 && inst_req && data_req)
                prio_m = (sel == 1);
        end
    end

    task automatic clr();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clr();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_m_req", m_req, 0);
        chk("lit_reset_err", err_stray_ok, 0);
        chk("lit_reset_inst_data_ok", inst_data_ok, 0);

        // Single fetch read
        inst_req = 1; inst_addr = 32'h1c000000; inst_size = 2'd2; m_addr_ok = 1; #1;
        chk("lit_t1_inst_addr_ok", inst_addr_ok, 1);
        chk("lit_t1_m_addr", m_addr, 32'h1c000000);
        chk("lit_t1_data_addr_ok", data_addr_ok, 0);
        step(); clr(); #1;
        chk("lit_t1_busy_pending", busy, 1);
        chk("lit_t1_addr_ok_drop", inst_addr_ok, 0);
        step(); m_data_ok = 1; m_rdata = 32'h12345678; #1;
        chk("lit_t1_inst_data_ok", inst_data_ok, 1);
        chk("lit_t1_inst_rdata", inst_rdata, 32'h12345678);
        chk("lit_t1_data_data_ok", data_data_ok, 0);
        step(); clr(); #1;
        chk("lit_t1_busy_done", busy, 0);

        // Contended pair
        inst_req = 1; inst_addr = 32'h1c000100; inst_size = 2'd2;
        data_req = 1; data_addr = 32'h00001000; data_wr = 1; data_wdata = 32'hdeadbeef;
        data_wstrb = 4'hf; data_size = 2'd2; m_addr_ok = 1; #1;
        chk("lit_t2_data_first", data_addr_ok, 1);
        chk("lit_t2_inst_waits", inst_addr_ok, 0);
        chk("lit_t2_m_wr", m_wr, 1);
        step(); data_req = 0; #1;
        chk("lit_t2_inst_second", inst_addr_ok, 1);
        step(); clr(); m_data_ok = 1; m_rdata = 32'hAAAA0001; #1;
        chk("lit_t2_resp_data", data_data_ok, 1);
        step(); m_rdata = 32'hBBBB0002; #1;
        chk("lit_t2_resp_inst", inst_data_ok, 1);
        step(); clr();
        inst_req = 1; inst_addr = 32'h1c000104; data_req = 1; data_addr = 32'h00001004;
        m_addr_ok = 1; #1;
`ifdef ARB_ROUND_ROBIN_EN
        chk("lit_t2b_inst_first", inst_addr_ok, 1);
        step(); inst_req = 0;
`else
        chk("lit_t2b_data_first", data_addr_ok, 1);
        step(); data_req = 0;
`endif
        step(); clr(); m_data_ok = 1; m_rdata = 32'h0000c001;
        step(); m_rdata = 32'h0000c002;
        step(); clr();

        // Grant held while slave stalls
        inst_req = 1; inst_addr = 32'h1c000200; #1;
        chk("lit_t3_m_addr_c1", m_addr, 32'h1c000200);
        step(); data_req = 1; data_addr = 32'h00002000; #1;
        chk("lit_t3_m_addr_c2", m_addr, 32'h1c000200);
        step(); #1;
        chk("lit_t3_m_addr_c3", m_addr, 32'h1c000200);
        step(); m_addr_ok = 1; #1;
        chk("lit_t3_inst_acc", inst_addr_ok, 1);
        chk("lit_t3_data_wait", data_addr_ok, 0);
        step(); inst_req = 0; #1;
        chk("lit_t3_data_acc", data_addr_ok, 1);
        step(); clr(); m_data_ok = 1; m_rdata = 32'h11; #1;
        chk("lit_t3_resp_inst", inst_data_ok, 1);
        step(); m_rdata = 32'h22; #1;
        chk("lit_t3_resp_data", data_data_ok, 1);
        step(); clr();

        // Full boundary, then pointer wrap
        data_req = 1; data_addr = 32'h00005000; m_addr_ok = 1;
        step(); data_addr = 32'h00005004;
        step(); data_addr = 32'h00005008; m_data_ok = 1; m_rdata = 32'h55; #1;
        chk("lit_t4_full_no_req", m_req, 0);
        chk("lit_t4_full_no_acc", data_addr_ok, 0);
        chk("lit_t4_full_pop", data_data_ok, 1);
        step(); m_data_ok = 0; #1;
        chk("lit_t4_resume", data_addr_ok, 1);
        step(); clr(); m_data_ok = 1; m_rdata = 32'h56;
        step(); m_rdata = 32'h57;
        step(); clr();
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 1) begin
                inst_req = 1; inst_addr = 32'h1c001000 + 32'(i * 4);
            end else begin
                data_req = 1; data_addr = 32'h00006000 + 32'(i * 4);
            end
            m_addr_ok = 1;
            m_data_ok = (i >= 1);
            m_rdata   = 32'(i);
            step(); clr();
        end
        m_data_ok = 1; m_rdata = 32'h99; #1;
        chk("lit_t4_last_is_inst", inst_data_ok, 1);
        step(); clr(); #1;
        chk("lit_t4_drained", busy, 0);

        // Stray response
        m_data_ok = 1; #1;
        chk("lit_t5_inst_data_ok", inst_data_ok, 0);
        chk("lit_t5_data_data_ok", data_data_ok, 0);
        step(); clr(); #1;
        chk("lit_t5_err", err_stray_ok, 1);
        step(); step(); #1;
        chk("lit_t5_err_sticky", err_stray_ok, 1);

        // Reset with an outstanding transaction and a locked grant
        data_req = 1; data_addr = 32'h00003000; m_addr_ok = 1;
        step(); clr(); inst_req = 1; inst_addr = 32'h1c000300;
        step(); #1;
        chk("lit_t6_busy_before", busy, 1);
        rst = 1;
        step(); rst = 0; clr(); data_req = 1; data_addr = 32'h00004000; #1;
        chk("lit_t6_busy_after", busy, 0);
        chk("lit_t6_err_cleared", err_stray_ok, 0);
        chk("lit_t6_m_req_live", m_req, 1);
        chk("lit_t6_m_addr_live", m_addr, 32'h00004000);
        step(); data_req = 0; #1;
        chk("lit_t6_drop_req", m_req, 0);
        chk("lit_t6_lock_busy", busy, 1);
        step(); inst_req = 1; inst_addr = 32'h1c000400; m_addr_ok = 1; #1;
        chk("lit_t6_locked_out", m_req, 0);
        chk("lit_t6_inst_no_ack", inst_addr_ok, 0);
        step(); data_req = 1; inst_req = 1; #1;
        chk("lit_t6_owner_acc", data_addr_ok, 1);
        step(); clr(); m_data_ok = 1; m_rdata = 32'h77; #1;
        chk("lit_t6_resp", data_data_ok, 1);
        step(); clr();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
